dsc_mul_seq: RTL and testbench
==============================

Name: dsc_mul_seq

Overview:
Job sequencer that sits directly in front of dsc_mul and drives it. Accepts one 4-operand job per valid/ready handshake and latches the operands. It then clears and enables the multiplier, waits for dsc_mul's ov flag, and captures z plus the run-cycle count. The result is presented downstream under a valid/ready handshake. It replaces bench-driven sequencing of rst/en with a synthesizable controller that includes a timeout.

Parameters:
NUM_BITS, 4, width of each operand a/b/c/d
ZW, 4*NUM_BITS, width of product z (matches dsc_mul output)
CYC_W, 32, width of cycle counter and res_cycles
TIMEOUT, 70000, max RUN cycles before a job is aborted (must be > 2^ZW)
ZERO_SKIP, 1, when 1 a job with any zero operand bypasses the multiplier

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset (0 = reset)
in_valid  in  1  job offered
in_ready  out  1  sequencer can accept a job
in_a, in_b, in_c, in_d  in  NUM_BITS each  operands
mul_a, mul_b, mul_c, mul_d  out  NUM_BITS each  latched operands to dsc_mul
mul_clr  out  1  synchronous active-high clear to dsc_mul rst
mul_en  out  1  enable to dsc_mul en
mul_z  in  ZW  dsc_mul z
mul_ov  in  1  dsc_mul ov (operation finished)
out_valid  out  1  result available
out_ready  in  1  consumer takes result
res_z  out  ZW  product
res_cycles  out  CYC_W  RUN cycles consumed by the job
res_err  out  1  job hit TIMEOUT
job_cnt  out  CYC_W  completed jobs since reset, wraps at 2^CYC_W

Behaviour:
- All outputs are registered. While rst=0: state=IDLE, in_ready=0, mul_clr=1, mul_en=0, out_valid=0, and res_z/res_cycles/res_err/job_cnt/mul_a..d=0. On the first clk edge after release, in_ready becomes 1.
- Async reset mid-job aborts the job with no output produced; the multiplier is held cleared.
- FSM states: IDLE, CLR, RUN, HOLD.
- IDLE: in_ready=1, mul_clr=1. The job is accepted on an edge with in_valid & in_ready: latch in_a..d into mul_a..d and set in_ready=0.
  - If ZERO_SKIP=1 and any operand is 0: go to HOLD with res_z=0, res_cycles=0, res_err=0 (out_valid high 1 edge after accept).
  - Otherwise go to CLR.
- CLR: exactly 1 cycle, mul_clr=1, mul_en=0, cycle counter cleared. Next state RUN. mul_ov is ignored in IDLE and CLR.
- RUN: mul_clr=0, mul_en=1. The counter increments on every RUN edge where mul_ov=0.
  - On an edge with mul_ov=1: res_z=mul_z, res_cycles=counter+1, res_err=0, mul_en=0, mul_clr=1, go to HOLD.
  - If the counter reaches TIMEOUT-1 with mul_ov still 0: res_z=mul_z, res_cycles=TIMEOUT, res_err=1, go to HOLD.
  - mul_ov takes priority if both conditions occur on the same edge.
- HOLD: out_valid=1. res_* are stable while out_valid=1 & out_ready=0. On an edge with out_ready=1: out_valid=0, job_cnt+1, go to IDLE (in_ready=1 next cycle). There is no accept in the same cycle as release, so the minimum job spacing is 2 cycles on the skip path.
- mul_a..d hold their values until the next accept.
- Arithmetic: res_z is the unsigned product, which fits ZW bits exactly (15^4=50625 < 2^16). The counter saturates at TIMEOUT and never wraps inside a job.

Test Plan:
- Reset release, then 15,15,15,15 with a dsc_mul model asserting ov after N cycles -> in_ready drops for the accept edge, CLR for 1 cycle, res_z=50625, res_cycles=N, res_err=0, job_cnt=1.
- ZERO_SKIP=1, job 3,5,0,7 -> mul_en never asserts, out_valid 1 cycle after accept, res_z=0, res_cycles=0; with ZERO_SKIP=0 the job goes through CLR/RUN.
- mul_ov tied 0, TIMEOUT=100, job 2,3,4,5 -> out_valid after 100 RUN cycles, res_err=1, res_cycles=100, mul_en=0 in HOLD.
- out_ready held low 10 cycles after out_valid -> res_z/res_cycles unchanged, in_ready=0 throughout, in_valid ignored; release -> IDLE, job_cnt increments once.
- rst pulled low at RUN cycle 50 -> out_valid=0, mul_en=0, mul_clr=1, job_cnt=0 immediately (async); next job 1,1,1,1 completes with res_z=1.
- 100 back-to-back random jobs with out_ready=1 -> every res_z equals a*b*c*d, job_cnt=100, no job dropped or duplicated.

Source files
------------

// File: rtl/dsc_mul_seq.sv
// Job sequencer in front of dsc_mul: takes a 4-operand job, clears and runs the
// multiplier until ov (or timeout), then presents the product and run length.
module dsc_mul_seq #(
  parameter int NUM_BITS  = 4,
  parameter int ZW        = 4*NUM_BITS,
  parameter int CYC_W     = 32,
  parameter int TIMEOUT   = 70000,
  parameter int ZERO_SKIP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_a,
  input  logic [NUM_BITS-1:0] in_b,
  input  logic [NUM_BITS-1:0] in_c,
  input  logic [NUM_BITS-1:0] in_d,
  output logic [NUM_BITS-1:0] mul_a,
  output logic [NUM_BITS-1:0] mul_b,
  output logic [NUM_BITS-1:0] mul_c,
  output logic [NUM_BITS-1:0] mul_d,
  output logic                mul_clr,
  output logic                mul_en,
  input  logic [ZW-1:0]       mul_z,
  input  logic                mul_ov,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ZW-1:0]       res_z,
  output logic [CYC_W-1:0]    res_cycles,
  output logic                res_err,
  output logic [CYC_W-1:0]    job_cnt
);

  typedef enum logic [1:0] {IDLE, CLR, RUN, HOLD} state_t;

  localparam logic [CYC_W-1:0] TO_MAX  = CYC_W'(TIMEOUT);
  localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(TIMEOUT - 1);

  state_t              state, state_nxt;
  logic [CYC_W-1:0]    cnt, cnt_nxt;
  logic                in_ready_nxt, mul_clr_nxt, mul_en_nxt, out_valid_nxt, res_err_nxt;
  logic [NUM_BITS-1:0] mul_a_nxt, mul_b_nxt, mul_c_nxt, mul_d_nxt;
  logic [ZW-1:0]       res_z_nxt;
  logic [CYC_W-1:0]    res_cycles_nxt, job_cnt_nxt;
  logic                has_zero;

  // Run counter never exceeds TIMEOUT, so it cannot wrap inside a job.
  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (v >= TO_MAX) ? TO_MAX : v + CYC_W'(1);
  endfunction

  assign has_zero = (in_a == '0) || (in_b == '0) || (in_c == '0) || (in_d == '0);

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    in_ready_nxt   = in_ready;
    mul_clr_nxt    = mul_clr;
    mul_en_nxt     = mul_en;
    out_valid_nxt  = out_valid;
    res_err_nxt    = res_err;
    mul_a_nxt      = mul_a;
    mul_b_nxt      = mul_b;
    mul_c_nxt      = mul_c;
    mul_d_nxt      = mul_d;
    res_z_nxt      = res_z;
    res_cycles_nxt = res_cycles;
    job_cnt_nxt    = job_cnt;
    case (state)
      IDLE: begin
        in_ready_nxt = 1'b1;
        mul_clr_nxt  = 1'b1;
        mul_en_nxt   = 1'b0;
        if (in_valid && in_ready) begin
          in_ready_nxt = 1'b0;
          mul_a_nxt    = in_a;
          mul_b_nxt    = in_b;
          mul_c_nxt    = in_c;
          mul_d_nxt    = in_d;
          if ((ZERO_SKIP != 0) && has_zero) begin
            state_nxt      = HOLD;
            out_valid_nxt  = 1'b1;
            res_z_nxt      = '0;
            res_cycles_nxt = '0;
            res_err_nxt    = 1'b0;
          end else begin
            state_nxt = CLR;
          end
        end
      end
      CLR: begin
        cnt_nxt     = '0;
        mul_clr_nxt = 1'b0;
        mul_en_nxt  = 1'b1;
        state_nxt   = RUN;
      end
      RUN: begin
        if (mul_ov || (cnt >= TO_LAST)) begin
          res_z_nxt      = mul_z;
          res_cycles_nxt = mul_ov ? sat_inc(cnt) : TO_MAX;
          res_err_nxt    = ~mul_ov;
          mul_en_nxt     = 1'b0;
          mul_clr_nxt    = 1'b1;
          out_valid_nxt  = 1'b1;
          state_nxt      = HOLD;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          job_cnt_nxt   = job_cnt + CYC_W'(1);
          in_ready_nxt  = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      in_ready   <= 1'b0;
      mul_clr    <= 1'b1;
      mul_en     <= 1'b0;
      out_valid  <= 1'b0;
      res_err    <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_c      <= '0;
      mul_d      <= '0;
      res_z      <= '0;
      res_cycles <= '0;
      job_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      in_ready   <= in_ready_nxt;
      mul_clr    <= mul_clr_nxt;
      mul_en     <= mul_en_nxt;
      out_valid  <= out_valid_nxt;
      res_err    <= res_err_nxt;
      mul_a      <= mul_a_nxt;
      mul_b      <= mul_b_nxt;
      mul_c      <= mul_c_nxt;
      mul_d      <= mul_d_nxt;
      res_z      <= res_z_nxt;
      res_cycles <= res_cycles_nxt;
      job_cnt    <= job_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Directed bench for dsc_mul_seq with a behavioural dsc_mul stand-in that raises
// ov after ov_n enabled cycles; a second instance covers ZERO_SKIP=0.
module tb_dsc_mul_seq;
  localparam int NB = 4;
  localparam int ZW = 16;
  localparam int CW = 32;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [NB-1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;

  logic in_ready, mul_clr, mul_en, mul_ov, out_valid, res_err;
  logic [NB-1:0] mul_a, mul_b, mul_c, mul_d;
  logic [ZW-1:0] mul_z, res_z;
  logic [CW-1:0] res_cycles, job_cnt;

  logic in_ready2, mul_clr2, mul_en2, mul_ov2, out_valid2, res_err2;
  logic [NB-1:0] mul_a2, mul_b2, mul_c2, mul_d2;
  logic [ZW-1:0] mul_z2, res_z2;
  logic [CW-1:0] res_cycles2, job_cnt2;

  int ov_n = 7;
  logic ov_on = 1'b1;
  logic [15:0] en_cnt = '0, en_cnt2 = '0;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dsc_mul_seq #(.NUM_BITS(NB), .ZW(ZW), .CYC_W(CW), .TIMEOUT(TO), .ZERO_SKIP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_d(mul_d),
    .mul_clr(mul_clr), .mul_en(mul_en), .mul_z(mul_z), .mul_ov(mul_ov),
    .out_valid(out_valid), .out_ready(out_ready), .res_z(res_z),
    .res_cycles(res_cycles), .res_err(res_err), .job_cnt(job_cnt));

  dsc_mul_seq #(.NUM_BITS(NB), .ZW(ZW), .CYC_W(CW), .TIMEOUT(TO), .ZERO_SKIP(0)) dut_ns (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .mul_a(mul_a2), .mul_b(mul_b2), .mul_c(mul_c2), .mul_d(mul_d2),
    .mul_clr(mul_clr2), .mul_en(mul_en2), .mul_z(mul_z2), .mul_ov(mul_ov2),
    .out_valid(out_valid2), .out_ready(1'b1), .res_z(res_z2),
    .res_cycles(res_cycles2), .res_err(res_err2), .job_cnt(job_cnt2));

  // Multiplier stand-ins: product is always visible, ov fires on the ov_n-th enabled edge.
  always @(posedge clk) begin
    if (mul_clr) en_cnt <= '0;
    else if (mul_en) en_cnt <= en_cnt + 16'd1;
    if (mul_clr2) en_cnt2 <= '0;
    else if (mul_en2) en_cnt2 <= en_cnt2 + 16'd1;
  end
  assign mul_z   = 16'(mul_a) * 16'(mul_b) * 16'(mul_c) * 16'(mul_d);
  assign mul_z2  = 16'(mul_a2) * 16'(mul_b2) * 16'(mul_c2) * 16'(mul_d2);
  assign mul_ov  = ov_on && mul_en && !mul_clr && (int'(en_cnt) == ov_n - 1);
  assign mul_ov2 = mul_en2 && !mul_clr2 && (int'(en_cnt2) == ov_n - 1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 300 && !in_ready; i++) tick();
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL wait_ready: in_ready=%b required 1", in_ready); end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 300) begin tick(); n++; end
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL wait_out: out_valid=%b required 1", out_valid); end
  endtask

  task automatic send(input int a, input int b, input int c, input int d);
    in_a = NB'(a); in_b = NB'(b); in_c = NB'(c); in_d = NB'(d);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    tests_run += 5;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    if (mul_clr !== 1'b1) begin tests_failed++; $display("FAIL rst_mul_clr: got %b required 1", mul_clr); end
    if (mul_en !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_en_valid: got %b%b required 00", mul_en, out_valid); end
    if (res_z !== 16'd0 || res_cycles !== 32'd0 || res_err !== 1'b0) begin tests_failed++; $display("FAIL rst_res: got z=%0d cyc=%0d err=%b required 0", res_z, res_cycles, res_err); end
    if (job_cnt !== 32'd0 || mul_a !== 4'd0) begin tests_failed++; $display("FAIL rst_cnt: got job_cnt=%0d mul_a=%0d required 0", job_cnt, mul_a); end
    rst = 1'b1;
    tick();
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_basic();
    int n;
    ov_n = 7; ov_on = 1'b1; out_ready = 1'b1;
    send(15, 15, 15, 15);
    tests_run += 2;
    if (in_ready !== 1'b0 || mul_a !== 4'd15) begin tests_failed++; $display("FAIL basic_accept: in_ready=%b mul_a=%0d required 0/15", in_ready, mul_a); end
    if (mul_clr !== 1'b1 || mul_en !== 1'b0) begin tests_failed++; $display("FAIL basic_clr: clr=%b en=%b required 1/0", mul_clr, mul_en); end
    tick();
    tests_run++;
    if (mul_clr !== 1'b0 || mul_en !== 1'b1) begin tests_failed++; $display("FAIL basic_run: clr=%b en=%b required 0/1", mul_clr, mul_en); end
    wait_out(n);
    tests_run += 3;
    if (res_z !== 16'd50625) begin tests_failed++; $display("FAIL basic_z: got %0d required 50625", res_z); end
    if (res_cycles !== 32'd7 || res_err !== 1'b0) begin tests_failed++; $display("FAIL basic_cycles: got %0d err=%b required 7/0", res_cycles, res_err); end
    if (mul_en !== 1'b0 || mul_clr !== 1'b1) begin tests_failed++; $display("FAIL basic_hold_mul: en=%b clr=%b required 0/1", mul_en, mul_clr); end
    tick();
    tests_run++;
    if (job_cnt !== 32'd1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_job_cnt: got %0d valid=%b required 1/0", job_cnt, out_valid); end
  endtask

  task automatic test_zero_skip();
    logic saw_en1, saw_en2;
    saw_en1 = 1'b0; saw_en2 = 1'b0;
    wait_ready();
    send(3, 5, 0, 7);
    tests_run += 2;
    if (out_valid !== 1'b1 || mul_en !== 1'b0) begin tests_failed++; $display("FAIL skip_valid: valid=%b en=%b required 1/0", out_valid, mul_en); end
    if (res_z !== 16'd0 || res_cycles !== 32'd0 || res_err !== 1'b0) begin tests_failed++; $display("FAIL skip_res: z=%0d cyc=%0d err=%b required 0", res_z, res_cycles, res_err); end
    for (int i = 0; i < 200 && !out_valid2; i++) begin
      tick();
      saw_en1 |= mul_en;
      saw_en2 |= mul_en2;
    end
    tests_run += 3;
    if (saw_en1 !== 1'b0) begin tests_failed++; $display("FAIL skip_no_en: saw mul_en=%b required 0", saw_en1); end
    if (saw_en2 !== 1'b1) begin tests_failed++; $display("FAIL noskip_en: saw mul_en=%b required 1", saw_en2); end
    if (out_valid2 !== 1'b1 || res_z2 !== 16'd0 || res_cycles2 !== 32'd7) begin tests_failed++; $display("FAIL noskip_res: valid=%b z=%0d cyc=%0d required 1/0/7", out_valid2, res_z2, res_cycles2); end
    tests_run++;
    if (job_cnt !== 32'd2) begin tests_failed++; $display("FAIL skip_job_cnt: got %0d required 2", job_cnt); end
  endtask

  task automatic test_timeout();
    int n;
    ov_on = 1'b0;
    wait_ready();
    send(2, 3, 4, 5);
    wait_out(n);
    tests_run += 4;
    if (n !== 101) begin tests_failed++; $display("FAIL to_latency: got %0d cycles after accept required 101", n); end
    if (res_err !== 1'b1 || res_cycles !== 32'd100) begin tests_failed++; $display("FAIL to_res: err=%b cyc=%0d required 1/100", res_err, res_cycles); end
    if (res_z !== 16'd120) begin tests_failed++; $display("FAIL to_z: got %0d required 120", res_z); end
    if (mul_en !== 1'b0) begin tests_failed++; $display("FAIL to_hold_en: got %b required 0", mul_en); end
    ov_on = 1'b1;
    tick();
  endtask

  task automatic test_hold();
    int n;
    int base;
    base = int'(job_cnt);
    out_ready = 1'b0;
    wait_ready();
    send(2, 2, 2, 2);
    wait_out(n);
    in_a = 4'd9; in_b = 4'd9; in_c = 4'd9; in_d = 4'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run += 3;
      if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_valid[%0d]: got %b required 1", i, out_valid); end
      if (res_z !== 16'd16 || res_cycles !== 32'd7) begin tests_failed++; $display("FAIL hold_res[%0d]: z=%0d cyc=%0d required 16/7", i, res_z, res_cycles); end
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_in_ready[%0d]: got %b required 0", i, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tests_run += 2;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL hold_release: valid=%b ready=%b required 0/1", out_valid, in_ready); end
    if (int'(job_cnt) !== base + 1) begin tests_failed++; $display("FAIL hold_job_cnt: got %0d required %0d", job_cnt, base + 1); end
    tick(); tick();
    tests_run += 2;
    if (int'(job_cnt) !== base + 1) begin tests_failed++; $display("FAIL hold_job_once: got %0d required %0d", job_cnt, base + 1); end
    if (mul_a !== 4'd2) begin tests_failed++; $display("FAIL hold_mul_a: got %0d required 2", mul_a); end
  endtask

  task automatic test_reset_mid();
    int n;
    ov_n = 60;
    wait_ready();
    send(1, 2, 3, 4);
    for (int i = 0; i < 50; i++) tick();
    tests_run++;
    if (mul_en !== 1'b1) begin tests_failed++; $display("FAIL mid_running: mul_en=%b required 1", mul_en); end
    rst = 1'b0;
    #1;
    tests_run += 2;
    if (out_valid !== 1'b0 || mul_en !== 1'b0 || mul_clr !== 1'b1) begin tests_failed++; $display("FAIL mid_async: valid=%b en=%b clr=%b required 0/0/1", out_valid, mul_en, mul_clr); end
    if (job_cnt !== 32'd0 || in_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_cnt: job_cnt=%0d ready=%b required 0/0", job_cnt, in_ready); end
    tick(); tick();
    ov_n = 7;
    rst = 1'b1;
    wait_ready();
    send(1, 1, 1, 1);
    wait_out(n);
    tests_run++;
    if (res_z !== 16'd1 || res_cycles !== 32'd7) begin tests_failed++; $display("FAIL mid_next_job: z=%0d cyc=%0d required 1/7", res_z, res_cycles); end
    tick();
    tests_run++;
    if (job_cnt !== 32'd1) begin tests_failed++; $display("FAIL mid_job_cnt: got %0d required 1", job_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q[$];
    logic [15:0] exp_z;
    int a, b, c, d, sent, rcvd, base;
    logic acc;
    base = int'(job_cnt);
    ov_n = 3; out_ready = 1'b1;
    sent = 0; rcvd = 0;
    a = $urandom_range(0, 15); b = $urandom_range(0, 15); c = $urandom_range(0, 15); d = $urandom_range(0, 15);
    in_a = NB'(a); in_b = NB'(b); in_c = NB'(c); in_d = NB'(d);
    in_valid = 1'b1;
    for (int t = 0; t < 5000 && rcvd < 100; t++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        q.push_back(16'(a * b * c * d));
        sent++;
        if (sent == 100) in_valid = 1'b0;
        else begin
          a = $urandom_range(0, 15); b = $urandom_range(0, 15); c = $urandom_range(0, 15); d = $urandom_range(0, 15);
          in_a = NB'(a); in_b = NB'(b); in_c = NB'(c); in_d = NB'(d);
        end
      end
      if (out_valid) begin
        exp_z = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        rcvd++;
        tests_run++;
        if (res_z !== exp_z) begin tests_failed++; $display("FAIL b2b_z[%0d]: got %0d required %0d", rcvd, res_z, exp_z); end
      end
    end
    in_valid = 1'b0;
    tick();
    tests_run += 2;
    if (rcvd !== 100 || q.size() !== 0) begin tests_failed++; $display("FAIL b2b_count: received %0d pending %0d required 100/0", rcvd, q.size()); end
    if (int'(job_cnt) !== base + 100) begin tests_failed++; $display("FAIL b2b_job_cnt: got %0d required %0d", job_cnt, base + 100); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_skip();
    test_timeout();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
